core_dbg_ctrl: RTL

Multi-hart debug control block: the parametrised successor of the single-hart core debug FSM. It instantiates one RUNNING/HALTED/RESUME state machine per hart and holds per-hart `dcsr`/`dpc` (optionally `dscratch0/1`). It serves a hart-addressed abstract register access port with registered read-back and error reporting, and produces halt/resume summary flags for the debug module. It sits between the debug module (DM) and the NUM_HARTS core pipelines.

---
 rtl/core_dbg_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/core_dbg_ctrl.sv
// core_dbg_ctrl: multi-hart debug control. One RUNNING/HALTED/RESUME FSM per
// hart with dcsr/dpc storage and a hart-addressed abstract register port.
// Ports: clk_i, reset_i (async, active-high); per-hart halt/resume requests,
// pipeline events (ebreak, trap, retire, PCs); per-hart state flags, dcsr_o,
// dpc_o, dont_trap_o, dbg_ret_o; any/all summaries; abstract access
// (en/wr/hart/ad/do in, di/valid/err out, registered one cycle after en).
// `define CORE_DBG_DSCRATCH_EN adds dscratch0/1 (0x7b2/0x7b3) per hart.
module core_dbg_ctrl #(
  parameter int          NUM_HARTS = 2,
  parameter int          HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  parameter logic [31:0] RESET_DPC = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_HARTS-1:0]      dbg_haltreq_i,
  input  logic [NUM_HARTS-1:0]      dbg_resumereq_i,
  input  logic [NUM_HARTS-1:0]      ebreak_inst_mem_i,
  input  logic [NUM_HARTS-1:0]      trap_i,
  input  logic [NUM_HARTS-1:0]      inst_valid_wb_i,
  input  logic [32*NUM_HARTS-1:0]   cinst_pc_i,
  input  logic [32*NUM_HARTS-1:0]   pc_if_jump_i,
  output logic [NUM_HARTS-1:0]      core_running_o,
  output logic [NUM_HARTS-1:0]      core_halted_o,
  output logic [NUM_HARTS-1:0]      core_resumeack_o,
  output logic [NUM_HARTS-1:0]      dbg_ret_o,
  output logic [NUM_HARTS-1:0]      dont_trap_o,
  output logic [32*NUM_HARTS-1:0]   dcsr_o,
  output logic [32*NUM_HARTS-1:0]   dpc_o,
  output logic                      anyhalted_o,
  output logic                      allhalted_o,
  output logic                      allresumeack_o,
  input  logic                      dbg_ar_en_i,
  input  logic                      dbg_ar_wr_i,
  input  logic [HART_W-1:0]         dbg_ar_hart_i,
  input  logic [15:0]               dbg_ar_ad_i,
  input  logic [31:0]               dbg_ar_do_i,
  output logic [31:0]               dbg_ar_di_o,
  output logic                      dbg_ar_valid_o,
  output logic                      dbg_ar_err_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_RES  = 2'b10
  } state_e;

  logic [NUM_HARTS-1:0]    hlt_only;
  logic [32*NUM_HARTS-1:0] ds0_v;
  logic [32*NUM_HARTS-1:0] ds1_v;

  logic        hart_ok;
  logic        sel_halt;
  logic        is_dcsr;
  logic        is_dpc;
  logic        is_ds0;
  logic        is_ds1;
  logic        ar_ok;
  logic        ar_wr;
  logic [31:0] sel_dcsr;
  logic [31:0] sel_dpc;
  logic [31:0] sel_ds0;
  logic [31:0] sel_ds1;
  logic [31:0] rdata;

  assign hart_ok = 32'(dbg_ar_hart_i) < NUM_HARTS;
  assign is_dcsr = dbg_ar_ad_i == 16'h07b0;
  assign is_dpc  = dbg_ar_ad_i == 16'h07b1;
`ifdef CORE_DBG_DSCRATCH_EN
  assign is_ds0  = dbg_ar_ad_i == 16'h07b2;
  assign is_ds1  = dbg_ar_ad_i == 16'h07b3;
`else
  assign is_ds0  = 1'b0;
  assign is_ds1  = 1'b0;
  assign ds0_v   = '0;
  assign ds1_v   = '0;
`endif

  // Registers are only reachable while the target hart is parked in HALTED.
  assign ar_ok = hart_ok & sel_halt
               & (is_dcsr | is_dpc | is_ds0 | is_ds1);
  assign ar_wr = dbg_ar_en_i & dbg_ar_wr_i & ar_ok;

  always_comb begin
    sel_halt = 1'b0;
    sel_dcsr = '0;
    sel_dpc  = '0;
    sel_ds0  = '0;
    sel_ds1  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (32'(dbg_ar_hart_i) == h) begin
        sel_halt = hlt_only[h];
        sel_dcsr = dcsr_o[h*32 +: 32];
        sel_dpc  = dpc_o[h*32 +: 32];
        sel_ds0  = ds0_v[h*32 +: 32];
        sel_ds1  = ds1_v[h*32 +: 32];
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_dcsr: rdata = sel_dcsr;
      is_dpc:  rdata = sel_dpc;
      is_ds0:  rdata = sel_ds0;
      is_ds1:  rdata = sel_ds1;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dbg_ar_valid_o <= 1'b0;
      dbg_ar_err_o   <= 1'b0;
      dbg_ar_di_o    <= '0;
    end else begin
      dbg_ar_valid_o <= dbg_ar_en_i;
      dbg_ar_err_o   <= dbg_ar_en_i & ~ar_ok;
      dbg_ar_di_o    <= (dbg_ar_en_i & ar_ok & ~dbg_ar_wr_i) ? rdata : '0;
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    state_e      st_q;
    state_e      prev_q;
    logic [2:0]  cause_q;
    logic [31:0] dpc_q;
    logic        ebm_q;
    logic [4:0]  b13_q;
    logic        mprven_q;
    logic        step_q;
    logic        eb_hit;
    logic        req_hit;
    logic        wr_sel;

    assign eb_hit  = ebreak_inst_mem_i[g] & ebm_q;
    assign req_hit = (step_q | dbg_haltreq_i[g])
                   & (trap_i[g] | inst_valid_wb_i[g]);
    assign wr_sel  = ar_wr & (32'(dbg_ar_hart_i) == g);

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        st_q    <= ST_RUN;
        prev_q  <= ST_RUN;
        cause_q <= '0;
        dpc_q   <= RESET_DPC;
      end else begin
        prev_q <= st_q;
        case (st_q)
          ST_RUN: begin
            if (eb_hit | req_hit) begin
              st_q    <= ST_HALT;
              cause_q <= eb_hit ? 3'd1
                       : (dbg_haltreq_i[g] ? 3'd3 : 3'd4);
              dpc_q   <= trap_i[g] ? pc_if_jump_i[g*32 +: 32]
                                   : cinst_pc_i[g*32 +: 32];
            end
          end
          ST_HALT: if (dbg_resumereq_i[g]) st_q <= ST_RES;
          ST_RES:  if (!dbg_resumereq_i[g]) st_q <= ST_RUN;
          default: st_q <= ST_RUN;
        endcase
        if (wr_sel & is_dpc) dpc_q <= dbg_ar_do_i;
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        ebm_q    <= 1'b0;
        b13_q    <= '0;
        mprven_q <= 1'b0;
        step_q   <= 1'b0;
      end else if (wr_sel & is_dcsr) begin
        ebm_q    <= dbg_ar_do_i[15];
        b13_q    <= dbg_ar_do_i[13:9];
        mprven_q <= dbg_ar_do_i[4];
        step_q   <= dbg_ar_do_i[2];
      end
    end

`ifdef CORE_DBG_DSCRATCH_EN
    logic [31:0] ds0_q;
    logic [31:0] ds1_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        ds0_q <= '0;
        ds1_q <= '0;
      end else begin
        if (wr_sel & is_ds0) ds0_q <= dbg_ar_do_i;
        if (wr_sel & is_ds1) ds1_q <= dbg_ar_do_i;
      end
    end
    assign ds0_v[g*32 +: 32] = ds0_q;
    assign ds1_v[g*32 +: 32] = ds1_q;
`endif

    assign core_running_o[g]   = st_q == ST_RUN;
    assign core_halted_o[g]    = (st_q == ST_HALT) | (st_q == ST_RES);
    assign core_resumeack_o[g] = st_q == ST_RES;
    assign hlt_only[g]         = st_q == ST_HALT;
    assign dbg_ret_o[g]        = (st_q == ST_RUN) & (prev_q == ST_RES);
    assign dont_trap_o[g]      = (st_q == ST_RUN)
      & (((step_q | dbg_haltreq_i[g]) & inst_valid_wb_i[g]) | eb_hit);
    assign dpc_o[g*32 +: 32]   = dpc_q;
    assign dcsr_o[g*32 +: 32]  = {4'd4, 12'd0, ebm_q, 1'b0, b13_q,
                                  cause_q, 1'b0, mprven_q, 1'b0,
                                  step_q, 2'd3};
  end

  assign anyhalted_o    = |core_halted_o;
  assign allhalted_o    = &core_halted_o;
  assign allresumeack_o = &core_resumeack_o;

endmodule
